// File: rtl/stereo_out_packer.sv
`default_nettype none
// ============================================================================
//  Module   : stereo_out_packer
//  Purpose  : Packs the disparity pixel stream from the stereo timing
//             generator into an AXI4-Stream video master.
//             - A frame opens with an SOF beat. Beats seen before the SOF
//               are discarded.
//             - Line and frame lengths are checked against IMAGE_WIDTH and
//               IMAGE_HEIGHT.
//             - Accepted beats go through a small first-word-fall-through
//               FIFO with an almost-full backpressure output.
//  Ports    : clk, rst_n            - clock, asynchronous active-low reset
//             en_in, sof_in, eol_in - pixel strobe and framing markers
//             data_in               - disparity pixel
//             m_axis_*              - AXI4-Stream master (tuser=SOF, tlast=EOL)
//             fifo_almost_full      - backpressure to the timing generator
//             frame_done            - one-cycle pulse after the last frame beat
//             line_cnt              - index of the line currently being written
//             overflow_err          - sticky: a beat was dropped (FIFO full)
//             length_err            - sticky: line or frame length mismatch
//             clear_err             - synchronous clear of both sticky flags
//  Revision : 1.0 - initial release
// ============================================================================
module stereo_out_packer #(
    parameter int DATA_WIDTH   = 8,
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    parameter int FIFO_DEPTH   = 16,
    parameter int AF_MARGIN    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_in,
    input  logic                  sof_in,
    input  logic                  eol_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tlast,
    output logic                  fifo_almost_full,
    output logic                  frame_done,
    output logic [9:0]            line_cnt,
    output logic                  overflow_err,
    output logic                  length_err,
    input  logic                  clear_err
);

    localparam int c_ptr_w   = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w   = c_ptr_w + 1;
    localparam int c_entry_w = DATA_WIDTH + 2;

    localparam logic [c_cnt_w-1:0] c_depth     = c_cnt_w'(FIFO_DEPTH);
    localparam logic [c_cnt_w-1:0] c_af_level  = c_cnt_w'(FIFO_DEPTH - AF_MARGIN);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one   = c_ptr_w'(1);
    localparam logic [9:0]         c_last_pix  = 10'(IMAGE_WIDTH - 1);
    localparam logic [9:0]         c_last_line = 10'(IMAGE_HEIGHT - 1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [9:0]           r_pix_cnt;
    logic [9:0]           r_line_cnt;
    logic                 r_frame_done;
    logic                 r_overflow_err;
    logic                 r_length_err;

    logic [c_entry_w-1:0] r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_cnt_w-1:0]   r_count;

    logic                 w_accept;
    logic [9:0]           w_pix_idx;
    logic [9:0]           w_line_idx;
    logic                 w_frame_end;
    logic                 w_len_err_set;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_wr;
    logic                 w_rd;
    logic                 w_ovf_set;
    logic [c_entry_w-1:0] w_head;

    // ------------------------------------------------------------------------
    // Beat classification and next state.
    // An SOF beat is pixel 0 of line 0 by definition, so the position of the
    // incoming beat is taken from the counters unless sof_in overrides it.
    // An accepted beat updates the counters and the FSM whether or not the
    // FIFO has room for it.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_accept      = 1'b0;
        w_pix_idx     = r_pix_cnt;
        w_line_idx    = r_line_cnt;
        w_frame_end   = 1'b0;
        w_len_err_set = 1'b0;
        w_full        = (r_count == c_depth);
        w_empty       = (r_count == '0);
        w_wr          = 1'b0;
        w_rd          = 1'b0;
        w_ovf_set     = 1'b0;

        if (sof_in) begin
            w_pix_idx  = '0;
            w_line_idx = '0;
        end

        case (r_state)
            IDLE:    w_accept = en_in && sof_in;
            STREAM:  w_accept = en_in;
            default: w_accept = 1'b0;
        endcase

        w_frame_end = w_accept && eol_in && (w_line_idx == c_last_line);

        // A short or long line is flagged at its EOL. An SOF arriving inside
        // a frame means the previous frame was cut short.
        w_len_err_set = w_accept &&
                        ((eol_in && (w_pix_idx != c_last_pix)) ||
                         (sof_in && (r_state == STREAM)));

        // Room is judged on the registered count only, so a read in the same
        // cycle does not rescue a write into a full FIFO.
        w_wr      = w_accept && !w_full;
        w_ovf_set = w_accept &&  w_full;
        w_rd      = !w_empty && m_axis_tready;

        if (w_accept) begin
            if (w_frame_end) begin
                w_state_next = IDLE;
            end else begin
                w_state_next = STREAM;
            end
        end
    end

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Pixel and line position
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_cnt    <= '0;
            r_line_cnt   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_frame_end;
            if (w_accept) begin
                r_pix_cnt <= eol_in ? 10'd0 : (w_pix_idx + 10'd1);
                if (w_frame_end) begin
                    r_line_cnt <= '0;
                end else if (eol_in) begin
                    r_line_cnt <= w_line_idx + 10'd1;
                end else begin
                    r_line_cnt <= w_line_idx;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Sticky error flags. A set in the same cycle as clear_err wins.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow_err <= 1'b0;
            r_length_err   <= 1'b0;
        end else begin
            if (w_ovf_set) begin
                r_overflow_err <= 1'b1;
            end else if (clear_err) begin
                r_overflow_err <= 1'b0;
            end

            if (w_len_err_set) begin
                r_length_err <= 1'b1;
            end else if (clear_err) begin
                r_length_err <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // FIFO pointers and occupancy. Pointers wrap naturally because the depth
    // is a power of two.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage has no reset. Contents are meaningless whenever the count is
    // zero, and the outputs are forced to zero in that case.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {sof_in, eol_in, data_in};
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. The head entry falls through to the stream. It changes only on
    // a read, so it holds while the consumer stalls.
    // ------------------------------------------------------------------------
    assign w_head           = r_mem[r_rd_ptr];
    assign m_axis_tvalid    = !w_empty;
    assign m_axis_tuser     = w_empty ? 1'b0 : w_head[c_entry_w-1];
    assign m_axis_tlast     = w_empty ? 1'b0 : w_head[c_entry_w-2];
    assign m_axis_tdata     = w_empty ? '0   : w_head[DATA_WIDTH-1:0];
    assign fifo_almost_full = (r_count >= c_af_level);
    assign frame_done       = r_frame_done;
    assign line_cnt         = r_line_cnt;
    assign overflow_err     = r_overflow_err;
    assign length_err       = r_length_err;

endmodule
`default_nettype wire

// File: doc/stereo_out_packer.md
STEREO_OUT_PACKER -- requirements
Module: stereo_out_packer

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of one disparity pixel.
REQ-002 Parameter IMAGE_WIDTH, default 640: pixels per line.
REQ-003 Parameter IMAGE_HEIGHT, default 480: lines per frame.
REQ-004 Parameter FIFO_DEPTH, default 16: output FIFO entries, power of two, at least 8.
REQ-005 Parameter AF_MARGIN, default 4: free entries remaining when fifo_almost_full asserts.
REQ-006 The block SHALL use one clock; reset is asynchronous and active-low. Ports:
- clk, input, 1: sole clock.
- rst_n, input, 1: asynchronous active-low reset.
- en_in, input, 1: pixel-valid strobe from the timing generator (EN qualified by pixelEN).
- sof_in, input, 1: first pixel of frame, qualified by en_in.
- eol_in, input, 1: last pixel of line, qualified by en_in.
- data_in, input, DATA_WIDTH: pixel value, qualified by en_in.
- m_axis_tdata, output, DATA_WIDTH: stream data.
- m_axis_tvalid, output, 1: stream valid.
- m_axis_tready, input, 1: stream ready.
- m_axis_tuser, output, 1: start of frame.
- m_axis_tlast, output, 1: end of line.
- fifo_almost_full, output, 1: backpressure to the timing generator's write-full input.
- frame_done, output, 1: one-cycle pulse after the last beat of a frame is written.
- line_cnt, output, 10: index of the line currently being written.
- overflow_err, output, 1: sticky flag, set when a write is dropped because the FIFO is full.
- length_err, output, 1: sticky flag, set on a line-length or frame-length mismatch.
- clear_err, input, 1: synchronous clear of both sticky flags.

Function
REQ-007 The FSM SHALL have two states, IDLE and STREAM.
REQ-008 In IDLE, beats with en_in=1 and sof_in=0 SHALL be discarded.
REQ-009 In IDLE, a beat with en_in=1 and sof_in=1 SHALL be written and the FSM SHALL move to STREAM.
REQ-010 In STREAM, every en_in=1 beat SHALL be written as {sof_in, eol_in, data_in}.
REQ-011 An internal pixel counter (10 bit) SHALL increment on each written beat and SHALL reset to 0 on a beat with eol_in=1 or sof_in=1.
REQ-012 line_cnt SHALL be set to 0 by a written SOF beat and SHALL increment after each written EOL beat.
REQ-013 A written eol_in beat when the pixel counter is not IMAGE_WIDTH-1 SHALL set length_err; the beat is still written with tlast=1.
REQ-014 An EOL beat when line_cnt is IMAGE_HEIGHT-1 SHALL pulse frame_done on the next cycle, return the FSM to IDLE, and reset line_cnt to 0.
REQ-015 A sof_in beat in STREAM SHALL set length_err, be written with tuser=1, restart line_cnt and the pixel counter, and keep the FSM in STREAM.
REQ-016 The FIFO SHALL be first-word-fall-through: m_axis_* SHALL reflect the head entry, and m_axis_tvalid=1 whenever the FIFO is not empty.
REQ-017 A read SHALL occur when m_axis_tvalid and m_axis_tready are both 1.
REQ-018 A write into an empty FIFO SHALL appear on m_axis_tvalid on the next cycle, giving 1-cycle latency; there is no same-cycle bypass.
REQ-019 The write decision SHALL use the registered occupancy count.
- If count equals FIFO_DEPTH, the write SHALL be dropped and overflow_err set, even if a read occurs in the same cycle.
- A dropped beat SHALL still advance the pixel counter, line_cnt and FSM exactly as if it had been written.
REQ-020 A simultaneous read and write SHALL leave the count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-021 fifo_almost_full SHALL be 1 when count is at least FIFO_DEPTH-AF_MARGIN, decoded from the registered count.
REQ-022 m_axis_tdata, m_axis_tuser and m_axis_tlast SHALL be held stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-023 clear_err SHALL clear both sticky flags; if a set condition occurs in the same cycle, set SHALL win.

Reset
REQ-024 rst_n=0 SHALL asynchronously force the FSM to IDLE, pointers, count, pixel counter and line_cnt to 0, and all outputs to 0.
REQ-025 Reset mid-frame SHALL discard FIFO contents; after release, input is ignored until the next sof_in beat.

Verification
REQ-026 Small frame (IMAGE_WIDTH=4, IMAGE_HEIGHT=2), tready=1, en_in every 8 cycles:
- 8 beats out; tuser on beat 0 only; tlast on beats 3 and 7.
- frame_done pulses once, 1 cycle after beat 7 is written; FSM returns to IDLE.
REQ-027 Pixels before SOF in IDLE, then SOF: the pre-SOF beats never appear on the stream; the first output beat has tuser=1.
REQ-028 tready=0 with FIFO_DEPTH=16, AF_MARGIN=4:
- fifo_almost_full rises the cycle after the 12th write.
- The 17th write sets overflow_err; occupancy stays 16; tdata holds at beat 0.
REQ-029 EOL after 3 pixels with IMAGE_WIDTH=4: length_err=1 and that beat has tlast=1; clear_err then drops length_err to 0 on the next cycle.
REQ-030 Full FIFO, tready=1, en_in=1 in the same cycle: the write is dropped, overflow_err sets, and count drops to 15.
REQ-031 rst_n asserted mid-line with 5 entries queued: tvalid=0 immediately; after release, non-SOF input produces no output.
